// File: rtl/pwm_fade_pkg.sv
// Shared state codes and level helpers for the PWM fade sequencer.
package pwm_fade_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_UP      = 3'd1;
   localparam logic [2:0] ST_HOLD_HI = 3'd2;
   localparam logic [2:0] ST_DOWN    = 3'd3;
   localparam logic [2:0] ST_HOLD_LO = 3'd4;

   // All-ones value for a level of the given width.
   function automatic int unsigned max_level(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Step prescaler: one tick every max(div,1) cycles, restarted by clr.
module step_tick_gen #(
   parameter int unsigned DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic                 clr,
   input  logic [DIV_WIDTH-1:0] div,
   output logic                 tick_c
);

   logic [DIV_WIDTH-1:0] cnt;
   logic [DIV_WIDTH-1:0] last;

   always_comb begin
      last   = (div == '0) ? '0 : div - DIV_WIDTH'(1);
      tick_c = (cnt == last);
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         cnt <= '0;
      end else if (clr || tick_c) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + DIV_WIDTH'(1);
      end
   end

endmodule

// File: rtl/pwm_fade_seq.sv
// Triangle brightness sequencer feeding a PWM threshold: up, hold, down, hold.
module pwm_fade_seq
   import pwm_fade_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DIV_WIDTH  = 16,
   parameter bit          INVERT     = 1'b1
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  oneshot,
   input  logic [DIV_WIDTH-1:0]  step_div,
   input  logic [DATA_WIDTH-1:0] step_size,
   input  logic [7:0]            hold_steps,
   output logic [DATA_WIDTH-1:0] threshold,
   output logic                  busy,
   output logic                  cycle_done,
   output logic [2:0]            phase
);

   localparam logic [DATA_WIDTH-1:0] LEVEL_MAX = DATA_WIDTH'(max_level(DATA_WIDTH));

   logic [2:0]            state, state_n;
   logic [DATA_WIDTH-1:0] level, level_n;
   logic [7:0]            hold_cnt, hold_n;
   logic                  done_n;
   logic                  latch;
   logic                  clr;
   logic                  tick_c;
   logic [DATA_WIDTH-1:0] step;
   logic [DATA_WIDTH:0]   sum;

   logic [DIV_WIDTH-1:0]  sh_div;
   logic [DATA_WIDTH-1:0] sh_size;
   logic [7:0]            sh_hold;
   logic                  sh_oneshot;

   step_tick_gen #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
      .clk    (clk),
      .nrst   (nrst),
      .clr    (clr),
      .div    (sh_div),
      .tick_c (tick_c)
   );

   // Next-state, level and hold counter; stop overrides everything.
   always_comb begin
      state_n = state;
      level_n = level;
      hold_n  = hold_cnt;
      done_n  = 1'b0;
      latch   = 1'b0;
      step    = (sh_size == '0) ? DATA_WIDTH'(1) : sh_size;
      sum     = {1'b0, level} + {1'b0, step};

      if (stop) begin
         state_n = ST_IDLE;
         level_n = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  latch   = 1'b1;
                  level_n = '0;
                  state_n = ST_UP;
               end
            end
            ST_UP: begin
               if (tick_c) begin
                  if (sum >= {1'b0, LEVEL_MAX}) begin
                     level_n = LEVEL_MAX;
                     hold_n  = 8'd0;
                     state_n = ST_HOLD_HI;
                  end else begin
                     level_n = sum[DATA_WIDTH-1:0];
                  end
               end
            end
            ST_HOLD_HI: begin
               if (tick_c) begin
                  if (hold_cnt == sh_hold) begin
                     state_n = ST_DOWN;
                  end else begin
                     hold_n = hold_cnt + 8'd1;
                  end
               end
            end
            ST_DOWN: begin
               if (tick_c) begin
                  if (level <= step) begin
                     level_n = '0;
                     hold_n  = 8'd0;
                     state_n = ST_HOLD_LO;
                  end else begin
                     level_n = level - step;
                  end
               end
            end
            ST_HOLD_LO: begin
               if (tick_c) begin
                  if (hold_cnt == sh_hold) begin
                     done_n = 1'b1;
                     if (sh_oneshot) begin
                        state_n = ST_IDLE;
                     end else begin
                        latch   = 1'b1;
                        state_n = ST_UP;
                     end
                  end else begin
                     hold_n = hold_cnt + 8'd1;
                  end
               end
            end
            default: begin
               state_n = ST_IDLE;
               level_n = '0;
            end
         endcase
      end

      // Every phase change restarts the step interval.
      clr = (state_n != state) || (state == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state      <= ST_IDLE;
         level      <= '0;
         hold_cnt   <= 8'd0;
         sh_div     <= '0;
         sh_size    <= '0;
         sh_hold    <= 8'd0;
         sh_oneshot <= 1'b0;
         threshold  <= INVERT ? '1 : '0;
         busy       <= 1'b0;
         cycle_done <= 1'b0;
         phase      <= ST_IDLE;
      end else begin
         state      <= state_n;
         level      <= level_n;
         hold_cnt   <= hold_n;
         if (latch) begin
            sh_div     <= step_div;
            sh_size    <= step_size;
            sh_hold    <= hold_steps;
            sh_oneshot <= oneshot;
         end
         threshold  <= INVERT ? ~level_n : level_n;
         busy       <= (state_n != ST_IDLE);
         cycle_done <= done_n;
         phase      <= state_n;
      end
   end

endmodule

// File: tb/tb_pwm_fade_seq.sv
// Scoreboard bench for pwm_fade_seq: expected phase/level runs are queued, then matched cycle by cycle.
`timescale 1ns/1ps
module tb_pwm_fade_seq;

   localparam logic [2:0] P_IDLE = 3'd0;
   localparam logic [2:0] P_UP   = 3'd1;
   localparam logic [2:0] P_HH   = 3'd2;
   localparam logic [2:0] P_DN   = 3'd3;
   localparam logic [2:0] P_HL   = 3'd4;

   typedef struct {
      logic [2:0] ph;
      logic [7:0] lv;
      int         cyc;
      bit         after_lo;
   } ev_t;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        oneshot = 1'b1;
   logic [15:0] step_div = 16'd0;
   logic [7:0]  step_size = 8'd0;
   logic [7:0]  hold_steps = 8'd0;

   logic [7:0]  threshold, thr_inv;
   logic        busy, busy_inv, cycle_done, done_inv;
   logic [2:0]  phase, phase_inv;

   int checks = 0;
   int failures = 0;

   ev_t        exp_q[$];
   ev_t        cur;
   int         done_at[$];
   int         arm_id = 0;
   int         seen_id = 0;
   bit         sb_busy = 1'b0;
   bit         sb_first = 1'b0;
   int         run_len = 0;
   int         cyc_cnt = 0;
   logic [2:0] prev_ph = 3'd0;
   logic [7:0] prev_thr = 8'd0;

   pwm_fade_seq #(.DATA_WIDTH(8), .DIV_WIDTH(16), .INVERT(1'b0)) dut (
      .clk(clk), .nrst(nrst), .start(start), .stop(stop), .oneshot(oneshot),
      .step_div(step_div), .step_size(step_size), .hold_steps(hold_steps),
      .threshold(threshold), .busy(busy), .cycle_done(cycle_done), .phase(phase)
   );

   pwm_fade_seq #(.DATA_WIDTH(8), .DIV_WIDTH(16), .INVERT(1'b1)) dut_inv (
      .clk(clk), .nrst(nrst), .start(start), .stop(stop), .oneshot(oneshot),
      .step_div(step_div), .step_size(step_size), .hold_steps(hold_steps),
      .threshold(thr_inv), .busy(busy_inv), .cycle_done(done_inv), .phase(phase_inv)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt++;

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   // Scoreboard: each run of constant {phase,threshold} must match the queued event and its length.
   always @(negedge clk) begin
      if (arm_id != seen_id) begin
         seen_id  = arm_id;
         sb_busy  = 1'b1;
         sb_first = 1'b1;
         done_at.delete();
      end
      if (sb_busy) begin
         if (sb_first || phase !== prev_ph || threshold !== prev_thr) begin
            if (!sb_first) begin
               checks++;
               if (run_len != cur.cyc) begin
                  failures++;
                  $display("FAIL run_length ph=%0d lv=%0d got=%0d required=%0d",
                           cur.ph, cur.lv, run_len, cur.cyc);
               end
            end
            sb_first = 1'b0;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_underflow got ph=%0d thr=%0d required no further change",
                        phase, threshold);
               sb_busy = 1'b0;
            end else begin
               cur = exp_q.pop_front();
               run_len = 0;
               checks++;
               if (phase !== cur.ph || threshold !== cur.lv || thr_inv !== ~cur.lv ||
                   busy !== (cur.ph != P_IDLE)) begin
                  failures++;
                  $display("FAIL sb_value got ph=%0d thr=%0d inv=%0d busy=%0b required ph=%0d thr=%0d inv=%0d busy=%0b",
                           phase, threshold, thr_inv, busy, cur.ph, cur.lv, ~cur.lv, (cur.ph != P_IDLE));
               end
            end
         end
         if (sb_busy) begin
            run_len++;
            checks++;
            if (cycle_done !== ((run_len == 1) && cur.after_lo)) begin
               failures++;
               $display("FAIL sb_cycle_done ph=%0d lv=%0d run=%0d got=%0b required=%0b",
                        cur.ph, cur.lv, run_len, cycle_done, ((run_len == 1) && cur.after_lo));
            end
            if (cycle_done === 1'b1) done_at.push_back(cyc_cnt);
            if (cur.cyc == 0) sb_busy = 1'b0;
         end
         prev_ph  = phase;
         prev_thr = threshold;
      end
   end

   function automatic void push_ev(logic [2:0] ph, logic [7:0] lv, int cyc, bit alo);
      ev_t e;
      e.ph = ph;
      e.lv = lv;
      e.cyc = cyc;
      e.after_lo = alo;
      exp_q.push_back(e);
   endfunction

   // Queues one full fade cycle; returns its length in clock cycles.
   function automatic int push_cycle(int d, int s, int h, bit first_after_lo);
      int dd = (d == 0) ? 1 : d;
      int ss = (s == 0) ? 1 : s;
      int lv = 0;
      int total = 0;
      bit alo = first_after_lo;
      while (1) begin
         push_ev(P_UP, 8'(lv), dd, alo);
         alo = 1'b0;
         total += dd;
         if (lv + ss >= 255) break;
         lv += ss;
      end
      push_ev(P_HH, 8'hFF, dd * (h + 1), 1'b0);
      total += dd * (h + 1);
      lv = 255;
      while (1) begin
         push_ev(P_DN, 8'(lv), dd, 1'b0);
         total += dd;
         if (lv <= ss) break;
         lv -= ss;
      end
      push_ev(P_HL, 8'h00, dd * (h + 1), 1'b0);
      total += dd * (h + 1);
      return total;
   endfunction

   task automatic kick();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      arm_id++;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_scoreboard(input int budget, input string name);
      int n = 0;
      @(negedge clk);
      while ((seen_id != arm_id || sb_busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb_busy || seen_id != arm_id || exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s_complete busy=%0b left=%0d required busy=0 left=0",
                  name, sb_busy, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (threshold !== 8'h00 || busy !== 1'b0 || phase !== 3'd0 || cycle_done !== 1'b0) begin
         failures++;
         $display("FAIL reset_plain got thr=%0h busy=%0b ph=%0d done=%0b required 00/0/0/0",
                  threshold, busy, phase, cycle_done);
      end
      checks++;
      if (thr_inv !== 8'hFF || busy_inv !== 1'b0 || phase_inv !== 3'd0 || done_inv !== 1'b0) begin
         failures++;
         $display("FAIL reset_inv got thr=%0h busy=%0b ph=%0d done=%0b required ff/0/0/0",
                  thr_inv, busy_inv, phase_inv, done_inv);
      end
      nrst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_oneshot();
      int t;
      step_div = 16'd2; step_size = 8'd64; hold_steps = 8'd0; oneshot = 1'b1;
      t = push_cycle(2, 64, 0, 1'b0);
      push_ev(P_IDLE, 8'h00, 0, 1'b1);
      kick();
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_scoreboard(t + 20, "oneshot");
      checks++;
      if (done_at.size() != 1) begin
         failures++;
         $display("FAIL oneshot_pulses got=%0d required=1", done_at.size());
      end
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || phase !== P_IDLE) begin
         failures++;
         $display("FAIL oneshot_idle got busy=%0b ph=%0d required 0/0", busy, phase);
      end
   endtask

   task automatic test_min_step();
      int t;
      step_div = 16'd0; step_size = 8'd0; hold_steps = 8'd0; oneshot = 1'b1;
      t = push_cycle(0, 0, 0, 1'b0);
      push_ev(P_IDLE, 8'h00, 0, 1'b1);
      kick();
      wait_scoreboard(t + 20, "min_step");
      checks++;
      if (t != 512) begin
         failures++;
         $display("FAIL min_step_len got=%0d required=512", t);
      end
   endtask

   task automatic test_continuous();
      int t;
      step_div = 16'd2; step_size = 8'd64; hold_steps = 8'd3; oneshot = 1'b0;
      t = push_cycle(2, 64, 3, 1'b0);
      void'(push_cycle(2, 64, 3, 1'b1));
      push_ev(P_UP, 8'h00, 0, 1'b1);
      kick();
      wait_scoreboard(2 * t + 20, "continuous");
      checks++;
      if (done_at.size() != 2) begin
         failures++;
         $display("FAIL cont_pulses got=%0d required=2", done_at.size());
      end else begin
         checks++;
         if (done_at[1] - done_at[0] != t) begin
            failures++;
            $display("FAIL cont_spacing got=%0d required=%0d", done_at[1] - done_at[0], t);
         end
      end
      @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      checks++;
      if (phase !== P_IDLE || busy !== 1'b0) begin
         failures++;
         $display("FAIL cont_stop got ph=%0d busy=%0b required 0/0", phase, busy);
      end
   endtask

   task automatic test_stop();
      int n = 0;
      int pulses = 0;
      step_div = 16'd2; step_size = 8'd64; hold_steps = 8'd0; oneshot = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (phase !== P_DN && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (phase !== P_DN) begin
         failures++;
         $display("FAIL stop_reach_down got ph=%0d required=%0d", phase, P_DN);
      end
      @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      checks++;
      if (phase !== P_IDLE || busy !== 1'b0 || threshold !== 8'h00 || thr_inv !== 8'hFF ||
          cycle_done !== 1'b0) begin
         failures++;
         $display("FAIL stop_abort got ph=%0d busy=%0b thr=%0h inv=%0h done=%0b required 0/0/00/ff/0",
                  phase, busy, threshold, thr_inv, cycle_done);
      end
      repeat (20) begin
         @(negedge clk);
         if (cycle_done === 1'b1 || phase !== P_IDLE) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         failures++;
         $display("FAIL stop_quiet got=%0d required=0", pulses);
      end
      start = 1'b1;
      stop = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop = 1'b0;
      checks++;
      if (phase !== P_IDLE || busy !== 1'b0) begin
         failures++;
         $display("FAIL start_stop_same got ph=%0d busy=%0b required 0/0", phase, busy);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (phase !== P_IDLE) begin
         failures++;
         $display("FAIL start_stop_later got ph=%0d required=0", phase);
      end
   endtask

   task automatic test_config_latch();
      int t;
      step_div = 16'd2; step_size = 8'd16; hold_steps = 8'd0; oneshot = 1'b0;
      t = push_cycle(2, 16, 0, 1'b0);
      t += push_cycle(2, 100, 0, 1'b1);
      push_ev(P_IDLE, 8'h00, 0, 1'b1);
      kick();
      repeat (3) @(negedge clk);
      step_size = 8'd100;
      oneshot = 1'b1;
      wait_scoreboard(t + 20, "config_latch");
      checks++;
      if (done_at.size() != 2) begin
         failures++;
         $display("FAIL latch_pulses got=%0d required=2", done_at.size());
      end
   endtask

   task automatic test_reset_inv();
      int n = 0;
      int t;
      step_div = 16'd2; step_size = 8'd64; hold_steps = 8'd3; oneshot = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (phase_inv !== P_HH && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (phase_inv !== P_HH || thr_inv !== 8'h00) begin
         failures++;
         $display("FAIL rst_reach_hold got ph=%0d thr=%0h required 2/00", phase_inv, thr_inv);
      end
      @(negedge clk);
      nrst = 1'b0;
      @(negedge clk);
      checks++;
      if (thr_inv !== 8'hFF || busy_inv !== 1'b0 || phase_inv !== P_IDLE || done_inv !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_hold got thr=%0h busy=%0b ph=%0d done=%0b required ff/0/0/0",
                  thr_inv, busy_inv, phase_inv, done_inv);
      end
      nrst = 1'b1;
      t = push_cycle(2, 64, 3, 1'b0);
      push_ev(P_IDLE, 8'h00, 0, 1'b1);
      kick();
      wait_scoreboard(t + 20, "reset_retry");
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_min_step();
      test_continuous();
      test_stop();
      test_config_latch();
      test_reset_inv();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
